ir_sense_ctrl: RTL and testbench
================================

IR_SENSE_CTRL -- requirements
Module: ir_sense_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 64: number of cycles IR_en is high before the sample is taken.
REQ-002 Parameter OFF_CYC, default 960: number of cycles IR_en is low between samples.
REQ-003 Parameter DBNC, default 3: number of consecutive agreeing samples required to change a filtered output; legal range 1..7.
REQ-004 clk  in  1  system clock; single clock domain; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 en  in  1  high enables the sampling schedule.
REQ-007 lftIR_n, cntrIR_n, rghtIR_n  in  1 each  raw active-low IR sensor inputs, asynchronous to clk.
REQ-008 clr_cnt  in  1  synchronous clear of line_cnt.
REQ-009 IR_en  out  1  powers the IR emitters.
REQ-010 lft_ir, cntr_ir, rght_ir  out  1 each  debounced active-high sensor states.
REQ-011 cntr_rise  out  1  one-cycle pulse on each 0->1 transition of cntr_ir.
REQ-012 line_cnt  out  4  count of centre-line crossings.
REQ-013 smpl_vld  out  1  one-cycle pulse marking the cycle in which the filtered outputs update.

Function
REQ-014 Each raw input SHALL pass through a 2-flop synchronizer; both flops are set to 1 (inactive) by reset.
REQ-015 FSM states:
  - IDLE -> SETTLE when en=1.
  - SETTLE -> SAMPLE after SETTLE_CYC cycles in SETTLE.
  - SAMPLE -> OFF after exactly 1 cycle.
  - OFF -> SETTLE after OFF_CYC cycles in OFF.
REQ-016 IR_en SHALL be registered and equal 1 exactly in SETTLE and SAMPLE, so each sample period is SETTLE_CYC+1+OFF_CYC cycles.
REQ-017 In SAMPLE, each channel SHALL capture its synchronized value, inverted to active-high, as that period's sample.
REQ-018 Per channel, an up counter counts consecutive samples that differ from the current filtered output.
  - When the count reaches DBNC, the filtered output toggles and the counter clears.
  - A sample that equals the filtered output clears the counter.
REQ-019 Filtered outputs and smpl_vld SHALL update in the cycle after SAMPLE.
REQ-020 cntr_rise SHALL be asserted in the same cycle cntr_ir goes 0->1, and in no other cycle.
REQ-021 line_cnt SHALL increment on cntr_rise and wrap from 15 to 0.
REQ-022 clr_cnt SHALL set line_cnt to 0 on the next edge; when clr_cnt and cntr_rise coincide, clr_cnt wins and the result is 0.
REQ-023 en deasserted in any state SHALL force IDLE on the next edge.
  - IR_en goes 0 and the phase counter clears.
  - Filtered outputs, debounce counters and line_cnt hold their values.
  - A SAMPLE that is aborted this way produces no update.
REQ-024 Re-asserting en SHALL restart the schedule at the start of SETTLE, with a full SETTLE_CYC wait.
REQ-025 The phase counter SHALL be sized by a $clog2 of max(SETTLE_CYC, OFF_CYC) and SHALL never wrap within a state.

Reset
REQ-026 On rst=1, the FSM SHALL go to IDLE and the phase counter and all debounce counters SHALL clear to 0.
REQ-027 On rst=1, IR_en=0, lft_ir=0, cntr_ir=0, rght_ir=0, cntr_rise=0, smpl_vld=0, line_cnt=0.
REQ-028 rst SHALL take priority over en and clr_cnt, and reset asserted mid-period SHALL abort the period with no sample update.

Structure
REQ-029 The FSM state enum SHALL live in a shared package, ir_pkg, together with the default constants for SETTLE_CYC, OFF_CYC and DBNC.
REQ-030 The per-channel synchronizer plus debounce logic SHALL be one sub-module, ir_dbnc, instantiated three times.
REQ-031 The FSM, phase counter, edge detect and line counter SHALL reside in ir_sense_ctrl.

Verification
Bench parameters: SETTLE_CYC=4, OFF_CYC=8, DBNC=3.
REQ-032 Schedule: en=1 held for 100 cycles -> IR_en high for 5 cycles and low for 8, repeating; the first rise is 1 cycle after en; smpl_vld pulses once per 13 cycles.
REQ-033 Debounce: lftIR_n=0 for 3 consecutive sample periods -> lft_ir rises with the 3rd smpl_vld; a pattern of 2 active samples then 1 inactive -> lft_ir stays 0.
REQ-034 Line count: cntrIR_n pulsed low for 4 periods and high for 4 periods, repeated 17 times -> 17 cntr_rise pulses and line_cnt=1 (after wrap).
REQ-035 Simultaneous events: clr_cnt asserted in the cntr_rise cycle with line_cnt=5 -> line_cnt=0.
REQ-036 Abort: en dropped in SETTLE, and separately rst pulsed in SAMPLE -> IR_en=0 next cycle and no smpl_vld; on re-enable, the first sample comes 5 cycles later.

Source files
------------

// File: rtl/ir_sense_ctrl_pkg.sv
// Shared state encoding, default timing constants and sizing helpers
// for the IR line-sensor controller.
package ir_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      OFF    = 2'd3
   } irState_t;

   localparam int SETTLE_CYC_DEF = 64;
   localparam int OFF_CYC_DEF    = 960;
   localparam int DBNC_DEF       = 3;

   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // The phase counter only ever counts to max-1, so clog2 of the larger
   // interval is enough; a width of at least one bit keeps degenerate
   // parameterisations legal.
   function automatic int phaseWidth(input int settleCyc, input int offCyc);
      int w;
      w = $clog2(maxInt(settleCyc, offCyc));
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/ir_sense_ctrl_if.sv
// Control and status bundle between the IR sensor controller and its host;
// the host side drives enable, raw sensor lines and the counter clear.
interface ir_sense_ctrl_if;

   logic       en;
   logic       lftIR_n;
   logic       cntrIR_n;
   logic       rghtIR_n;
   logic       clr_cnt;
   logic       IR_en;
   logic       lft_ir;
   logic       cntr_ir;
   logic       rght_ir;
   logic       cntr_rise;
   logic       smpl_vld;
   logic [3:0] line_cnt;

   modport master (
      output en, lftIR_n, cntrIR_n, rghtIR_n, clr_cnt,
      input  IR_en, lft_ir, cntr_ir, rght_ir, cntr_rise, smpl_vld, line_cnt
   );

   modport slave (
      input  en, lftIR_n, cntrIR_n, rghtIR_n, clr_cnt,
      output IR_en, lft_ir, cntr_ir, rght_ir, cntr_rise, smpl_vld, line_cnt
   );

endinterface

// File: rtl/ir_sense_ctrl_dbnc.sv
// One sensor channel: 2-flop synchronizer on the raw active-low input followed
// by a consecutive-sample debounce filter that only advances on a sample strobe.
module ir_dbnc
   import ir_pkg::*;
#(
   parameter int DBNC = DBNC_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_rawN,
   input  logic i_smplStb,
   output logic o_filt
);

   logic       r_sync1;
   logic       r_sync2;
   logic       r_filt;
   logic [2:0] r_cnt;
   logic       w_smpl;
   logic [2:0] w_cntInc;

   assign w_smpl   = ~r_sync2;
   assign w_cntInc = r_cnt + 3'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_rawN;
         r_sync2 <= r_sync1;
      end
   end

   // Any agreeing sample restarts the run; DBNC disagreeing samples in a row flip the output.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_filt <= 1'b0;
         r_cnt  <= 3'd0;
      end else if (i_smplStb) begin
         if (w_smpl == r_filt) begin
            r_cnt <= 3'd0;
         end else if (w_cntInc == 3'(DBNC)) begin
            r_filt <= ~r_filt;
            r_cnt  <= 3'd0;
         end else begin
            r_cnt <= w_cntInc;
         end
      end
   end

   assign o_filt = r_filt;

endmodule

// File: rtl/ir_sense_ctrl.sv
// IR sensor sequencer: powers the emitters on a settle/sample/off schedule,
// debounces the three line sensors once per period and counts centre-line crossings.
module ir_sense_ctrl
   import ir_pkg::*;
#(
   parameter int SETTLE_CYC = SETTLE_CYC_DEF,
   parameter int OFF_CYC    = OFF_CYC_DEF,
   parameter int DBNC       = DBNC_DEF
) (
   input  logic           clk,
   input  logic           rst,
   ir_sense_ctrl_if.slave bus
);

   localparam int              PH_W        = phaseWidth(SETTLE_CYC, OFF_CYC);
   localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
   localparam logic [PH_W-1:0] OFF_LAST    = PH_W'(OFF_CYC - 1);

   irState_t        r_state;
   irState_t        w_nextState;
   logic [PH_W-1:0] r_phase;
   logic [PH_W-1:0] w_phaseNext;
   logic            w_irEnNext;
   logic            w_smplStb;
   logic            r_irEn;
   logic            r_smplVld;
   logic            w_lftIr;
   logic            w_cntrIr;
   logic            w_rghtIr;
   logic            r_cntrPrev;
   logic            w_cntrRise;
   logic [3:0]      r_lineCnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_phase <= '0;
      end else begin
         r_state <= w_nextState;
         r_phase <= w_phaseNext;
      end
   end

   // Dropping en aborts from any state, including a sample in progress.
   always_comb begin
      w_nextState = r_state;
      if (!bus.en) begin
         w_nextState = IDLE;
      end else begin
         case (r_state)
            IDLE:    w_nextState = SETTLE;
            SETTLE:  if (r_phase == SETTLE_LAST) w_nextState = SAMPLE;
            SAMPLE:  w_nextState = OFF;
            OFF:     if (r_phase == OFF_LAST) w_nextState = SETTLE;
            default: w_nextState = IDLE;
         endcase
      end
   end

   always_comb begin
      w_irEnNext  = (w_nextState == SETTLE) || (w_nextState == SAMPLE);
      w_smplStb   = (r_state == SAMPLE) && bus.en;
      w_phaseNext = '0;
      if ((w_nextState == r_state) && (r_state != IDLE)) begin
         w_phaseNext = r_phase + PH_W'(1);
      end
   end

   // IR_en is registered from the next state so it lines up exactly with SETTLE/SAMPLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_irEn    <= 1'b0;
         r_smplVld <= 1'b0;
      end else begin
         r_irEn    <= w_irEnNext;
         r_smplVld <= w_smplStb;
      end
   end

   ir_dbnc #(.DBNC(DBNC)) u_lftDbnc (
      .clk       (clk),
      .rst       (rst),
      .i_rawN    (bus.lftIR_n),
      .i_smplStb (w_smplStb),
      .o_filt    (w_lftIr)
   );

   ir_dbnc #(.DBNC(DBNC)) u_cntrDbnc (
      .clk       (clk),
      .rst       (rst),
      .i_rawN    (bus.cntrIR_n),
      .i_smplStb (w_smplStb),
      .o_filt    (w_cntrIr)
   );

   ir_dbnc #(.DBNC(DBNC)) u_rghtDbnc (
      .clk       (clk),
      .rst       (rst),
      .i_rawN    (bus.rghtIR_n),
      .i_smplStb (w_smplStb),
      .o_filt    (w_rghtIr)
   );

   assign w_cntrRise = w_cntrIr & ~r_cntrPrev;

   // A clear arriving together with a crossing wins, leaving the count at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cntrPrev <= 1'b0;
         r_lineCnt  <= 4'd0;
      end else begin
         r_cntrPrev <= w_cntrIr;
         if (bus.clr_cnt) begin
            r_lineCnt <= 4'd0;
         end else if (w_cntrRise) begin
            r_lineCnt <= r_lineCnt + 4'd1;
         end
      end
   end

   assign bus.IR_en     = r_irEn;
   assign bus.smpl_vld  = r_smplVld;
   assign bus.lft_ir    = w_lftIr;
   assign bus.cntr_ir   = w_cntrIr;
   assign bus.rght_ir   = w_rghtIr;
   assign bus.cntr_rise = w_cntrRise;
   assign bus.line_cnt  = r_lineCnt;

endmodule

// File: tb/tb_ir_sense_ctrl.sv
// Self-checking bench for ir_sense_ctrl: a schedule/debounce reference model
// built from period arithmetic runs alongside the DUT and is compared every cycle.
module tb_ir_sense_ctrl;

   localparam int SETTLE = 4;
   localparam int OFF    = 8;
   localparam int DBNC   = 3;
   localparam int PERIOD = SETTLE + 1 + OFF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nTests = 0;
   int   nFail  = 0;

   ir_sense_ctrl_if bus ();

   ir_sense_ctrl #(
      .SETTLE_CYC (SETTLE),
      .OFF_CYC    (OFF),
      .DBNC       (DBNC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: mT is the cycle index since the schedule (re)started, -1 when idle.
   int         mT = -1;
   logic [2:0] mFilt = 3'b000;
   int         mRun[3];
   logic [2:0] h1 = 3'b111;
   logic [2:0] h2 = 3'b111;
   logic       mSmplVld = 1'b0;
   logic       mRise = 1'b0;
   int         mLine = 0;
   logic [2:0] mRawNow;
   logic [2:0] mSmpl;
   logic       mOldC;
   logic       mDoSmpl;

   always @(posedge clk) begin
      mRawNow = {bus.rghtIR_n, bus.cntrIR_n, bus.lftIR_n};
      if (rst) begin
         mT       = -1;
         mFilt    = 3'b000;
         mRun     = '{default: 0};
         h1       = 3'b111;
         h2       = 3'b111;
         mSmplVld = 1'b0;
         mRise    = 1'b0;
         mLine    = 0;
      end else begin
         mDoSmpl = bus.en && (mT >= 0) && ((mT % PERIOD) == SETTLE);
         if (bus.clr_cnt) mLine = 0;
         else if (mRise) mLine = (mLine + 1) % 16;
         mOldC = mFilt[1];
         mSmpl = ~h2;
         if (mDoSmpl) begin
            for (int ch = 0; ch < 3; ch++) begin
               if (mSmpl[ch] == mFilt[ch]) begin
                  mRun[ch] = 0;
               end else begin
                  mRun[ch] = mRun[ch] + 1;
                  if (mRun[ch] == DBNC) begin
                     mFilt[ch] = ~mFilt[ch];
                     mRun[ch]  = 0;
                  end
               end
            end
         end
         mSmplVld = mDoSmpl;
         mRise    = mFilt[1] & ~mOldC;
         h2       = h1;
         h1       = mRawNow;
         mT       = bus.en ? mT + 1 : -1;
      end
   end

   function automatic logic [9:0] expVec();
      logic irEn;
      irEn = (mT >= 0) && ((mT % PERIOD) <= SETTLE);
      return {irEn, mFilt[0], mFilt[1], mFilt[2], mRise, mSmplVld, 4'(mLine)};
   endfunction

   function automatic logic [9:0] dutVec();
      return {bus.IR_en, bus.lft_ir, bus.cntr_ir, bus.rght_ir,
              bus.cntr_rise, bus.smpl_vld, bus.line_cnt};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setRaw(input logic lftN, input logic cntrN, input logic rghtN);
      bus.lftIR_n  = lftN;
      bus.cntrIR_n = cntrN;
      bus.rghtIR_n = rghtN;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.en = 1'b0;
      bus.clr_cnt = 1'b0;
      setRaw(1'b0, 1'b0, 1'b0);
      tick();
      tick();
      @(negedge clk);
      nTests++;
      if (dutVec() !== 10'b0) begin
         nFail++;
         $display("[TB] FAIL reset_outputs: got %b expected %b", dutVec(), 10'b0);
      end
      bus.en = 1'b1;
      bus.clr_cnt = 1'b1;
      tick();
      tick();
      @(negedge clk);
      nTests++;
      if (dutVec() !== 10'b0) begin
         nFail++;
         $display("[TB] FAIL reset_priority: got %b expected %b", dutVec(), 10'b0);
      end
      bus.en = 1'b0;
      bus.clr_cnt = 1'b0;
      setRaw(1'b1, 1'b1, 1'b1);
      tick();
      rst = 1'b0;
   endtask

   task automatic test_schedule();
      int highCnt = 0;
      int vldCnt = 0;
      logic firstIrEn = 1'b0;
      bus.en = 1'b1;
      for (int c = 0; c < 100; c++) begin
         tick();
         @(negedge clk);
         if (c == 0) firstIrEn = bus.IR_en;
         if (bus.IR_en === 1'b1) highCnt++;
         if (bus.smpl_vld === 1'b1) vldCnt++;
         nTests++;
         if (dutVec() !== expVec()) begin
            nFail++;
            $display("[TB] FAIL schedule cyc %0d: got %b expected %b", c, dutVec(), expVec());
         end
      end
      nTests++;
      if (firstIrEn !== 1'b1) begin
         nFail++;
         $display("[TB] FAIL schedule_first_rise: got %b expected 1", firstIrEn);
      end
      nTests++;
      if (highCnt != 40) begin
         nFail++;
         $display("[TB] FAIL schedule_iren_cycles: got %0d expected 40", highCnt);
      end
      nTests++;
      if (vldCnt != 8) begin
         nFail++;
         $display("[TB] FAIL schedule_smpl_vld_count: got %0d expected 8", vldCnt);
      end
      bus.en = 1'b0;
      tick();
   endtask

   task automatic test_debounce();
      int vldSeen = 0;
      int riseAt = -1;
      logic vldAtRise = 1'b0;
      int lftHigh = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      setRaw(1'b0, 1'b1, 1'b1);
      bus.en = 1'b1;
      for (int c = 0; c < 60; c++) begin
         tick();
         @(negedge clk);
         if (bus.smpl_vld === 1'b1) vldSeen++;
         if ((bus.lft_ir === 1'b1) && (riseAt < 0)) begin
            riseAt = vldSeen;
            vldAtRise = bus.smpl_vld;
         end
         nTests++;
         if (dutVec() !== expVec()) begin
            nFail++;
            $display("[TB] FAIL debounce_steady cyc %0d: got %b expected %b", c, dutVec(), expVec());
         end
      end
      nTests++;
      if ((riseAt != 3) || (vldAtRise !== 1'b1)) begin
         nFail++;
         $display("[TB] FAIL debounce_rise_on_third: got sample %0d vld %b expected sample 3 vld 1",
                  riseAt, vldAtRise);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int p = 0; p < 6; p++) begin
         setRaw((p % 3) == 2, 1'b1, 1'b1);
         for (int c = 0; c < PERIOD; c++) begin
            tick();
            @(negedge clk);
            if (bus.lft_ir !== 1'b0) lftHigh++;
            nTests++;
            if (dutVec() !== expVec()) begin
               nFail++;
               $display("[TB] FAIL debounce_broken p %0d cyc %0d: got %b expected %b",
                        p, c, dutVec(), expVec());
            end
         end
      end
      nTests++;
      if (lftHigh != 0) begin
         nFail++;
         $display("[TB] FAIL debounce_broken_stays_low: got %0d high cycles expected 0", lftHigh);
      end
      bus.en = 1'b0;
      setRaw(1'b1, 1'b1, 1'b1);
      tick();
   endtask

   task automatic test_line_count();
      int rises = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.en = 1'b1;
      for (int r = 0; r < 17; r++) begin
         for (int p = 0; p < 8; p++) begin
            setRaw(1'b1, p >= 4, 1'b1);
            for (int c = 0; c < PERIOD; c++) begin
               tick();
               @(negedge clk);
               if (bus.cntr_rise === 1'b1) rises++;
               nTests++;
               if (dutVec() !== expVec()) begin
                  nFail++;
                  $display("[TB] FAIL line_count r %0d p %0d cyc %0d: got %b expected %b",
                           r, p, c, dutVec(), expVec());
               end
            end
         end
      end
      nTests++;
      if (rises != 17) begin
         nFail++;
         $display("[TB] FAIL line_rise_count: got %0d expected 17", rises);
      end
      nTests++;
      if (bus.line_cnt !== 4'd1) begin
         nFail++;
         $display("[TB] FAIL line_wrap: got %0d expected 1", bus.line_cnt);
      end
      bus.en = 1'b0;
      tick();
   endtask

   task automatic test_clear_collision();
      logic checkNext = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.en = 1'b1;
      for (int r = 0; r < 6; r++) begin
         for (int p = 0; p < 8; p++) begin
            setRaw(1'b1, p >= 4, 1'b1);
            for (int c = 0; c < PERIOD; c++) begin
               tick();
               bus.clr_cnt = (mLine == 5) && mRise;
               @(negedge clk);
               if (checkNext) begin
                  checkNext = 1'b0;
                  nTests++;
                  if (bus.line_cnt !== 4'd0) begin
                     nFail++;
                     $display("[TB] FAIL clr_collision: got %0d expected 0", bus.line_cnt);
                  end
               end
               if (bus.clr_cnt) checkNext = 1'b1;
               nTests++;
               if (dutVec() !== expVec()) begin
                  nFail++;
                  $display("[TB] FAIL clr_run r %0d p %0d cyc %0d: got %b expected %b",
                           r, p, c, dutVec(), expVec());
               end
            end
         end
      end
      bus.clr_cnt = 1'b0;
      bus.en = 1'b0;
      tick();
   endtask

   task automatic test_abort();
      int vldIdle = 0;
      int riseAt = -1;
      int smplAt = -1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.en = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (mT == 2) break;
      end
      bus.en = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         @(negedge clk);
         if (c == 0) begin
            nTests++;
            if (bus.IR_en !== 1'b0) begin
               nFail++;
               $display("[TB] FAIL abort_en_iren: got %b expected 0", bus.IR_en);
            end
         end
         if (bus.smpl_vld !== 1'b0) vldIdle++;
         nTests++;
         if (dutVec() !== expVec()) begin
            nFail++;
            $display("[TB] FAIL abort_en_idle cyc %0d: got %b expected %b", c, dutVec(), expVec());
         end
      end
      nTests++;
      if (vldIdle != 0) begin
         nFail++;
         $display("[TB] FAIL abort_en_no_sample: got %0d pulses expected 0", vldIdle);
      end
      bus.en = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         @(negedge clk);
         if ((bus.IR_en === 1'b1) && (riseAt < 0)) riseAt = k;
         if ((bus.smpl_vld === 1'b1) && (smplAt < 0)) smplAt = k;
      end
      nTests++;
      if ((riseAt != 1) || (smplAt - riseAt != 5)) begin
         nFail++;
         $display("[TB] FAIL abort_en_restart: got rise %0d sample %0d expected rise 1 sample 6",
                  riseAt, smplAt);
      end
      for (int c = 0; c < 30; c++) begin
         tick();
         if ((mT >= 0) && ((mT % PERIOD) == SETTLE)) break;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      nTests++;
      if ((bus.IR_en !== 1'b0) || (bus.smpl_vld !== 1'b0)) begin
         nFail++;
         $display("[TB] FAIL abort_rst_sample: got IR_en %b smpl_vld %b expected 0 0",
                  bus.IR_en, bus.smpl_vld);
      end
      riseAt = -1;
      smplAt = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         @(negedge clk);
         if ((bus.IR_en === 1'b1) && (riseAt < 0)) riseAt = k;
         if ((bus.smpl_vld === 1'b1) && (smplAt < 0)) smplAt = k;
      end
      nTests++;
      if ((riseAt != 1) || (smplAt - riseAt != 5)) begin
         nFail++;
         $display("[TB] FAIL abort_rst_restart: got rise %0d sample %0d expected rise 1 sample 6",
                  riseAt, smplAt);
      end
      bus.en = 1'b0;
      tick();
   endtask

   task automatic test_random();
      logic [2:0] raw;
      raw = 3'b111;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.en = 1'b1;
      for (int c = 0; c < 800; c++) begin
         for (int ch = 0; ch < 3; ch++) begin
            if ($urandom_range(0, 29) == 0) raw[ch] = ~raw[ch];
         end
         setRaw(raw[0], raw[1], raw[2]);
         if (bus.en) begin
            if ($urandom_range(0, 59) == 0) bus.en = 1'b0;
         end else begin
            if ($urandom_range(0, 7) == 0) bus.en = 1'b1;
         end
         bus.clr_cnt = ($urandom_range(0, 49) == 0);
         rst = ($urandom_range(0, 399) == 0);
         tick();
         @(negedge clk);
         nTests++;
         if (dutVec() !== expVec()) begin
            nFail++;
            $display("[TB] FAIL random cyc %0d: got %b expected %b", c, dutVec(), expVec());
         end
      end
      rst = 1'b0;
      bus.en = 1'b0;
      bus.clr_cnt = 1'b0;
      tick();
   endtask

   initial begin
      bus.en       = 1'b0;
      bus.clr_cnt  = 1'b0;
      bus.lftIR_n  = 1'b1;
      bus.cntrIR_n = 1'b1;
      bus.rghtIR_n = 1'b1;
      test_reset();
      test_schedule();
      test_debounce();
      test_line_count();
      test_clear_collision();
      test_abort();
      test_random();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
